// File: rtl/julia_pkg.sv
// Shared types and arithmetic helpers for the Julia iteration engine.
// Build option: define JULIA_SAT_EN to clamp an overflowing z update to the
// signed WIDTH limits. Leave it undefined to let the update wrap.
package julia_pkg;

   // Engine sequencing: IDLE waits for a point, MUL squares z, ADD tests and updates,
   // and DONE holds the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Widest operand the helpers support. Intermediates carry two guard bits
   // above a full double-width product, so sums and differences never wrap.
   localparam int JW_MAX = 64;
   localparam int WIDE_W = 2 * JW_MAX + 2;

   typedef logic signed [WIDE_W-1:0] wide_t;

   typedef struct packed {
      logic              ovf;
      logic [JW_MAX-1:0] val;
   } sow_t;

   // |z|^2 threshold of 4.0 at double-fraction scale (the scale of the products).
   function automatic wide_t esc_thresh(input int frac);
      return wide_t'(3'd4) <<< (2 * frac);
   endfunction

   // Range-checks a wide update against signed w-bit limits. The low w bits of
   // .val hold either the clamped value or the wrapped value.
   function automatic sow_t sat_or_wrap(input wide_t v, input int w);
      wide_t hi;
      wide_t lo;
      sow_t  r;
      hi    = (wide_t'(1'b1) <<< (w - 1)) - wide_t'(1'b1);
      lo    = -(wide_t'(1'b1) <<< (w - 1));
      r.ovf = (v > hi) || (v < lo);
`ifdef JULIA_SAT_EN
      if (v > hi) begin
         r.val = hi[JW_MAX-1:0];
      end else if (v < lo) begin
         r.val = lo[JW_MAX-1:0];
      end else begin
         r.val = v[JW_MAX-1:0];
      end
`else
      r.val = v[JW_MAX-1:0];
`endif
      return r;
   endfunction

endpackage

// File: rtl/julia_csq_stage.sv
// Registered complex-square product stage. When en is high it captures the
// full-precision products re*re, im*im and re*im. It can be reused per lane.
module julia_csq_stage #(
   parameter int WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      en,
   input  logic signed [WIDTH-1:0]   re,
   input  logic signed [WIDTH-1:0]   im,
   output logic signed [2*WIDTH-1:0] rr,
   output logic signed [2*WIDTH-1:0] ii,
   output logic signed [2*WIDTH-1:0] ri
);

   localparam int PW = 2 * WIDTH;

   logic signed [PW-1:0] re_x_s;
   logic signed [PW-1:0] im_x_s;

   // Sign-extend the operands so each double-width product is exact.
   always_comb begin
      re_x_s = {{WIDTH{re[WIDTH-1]}}, re};
      im_x_s = {{WIDTH{im[WIDTH-1]}}, im};
   end

   // Product registers: cleared by reset or clr, loaded when enabled, otherwise held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr <= '0;
         ii <= '0;
         ri <= '0;
      end else if (clr) begin
         rr <= '0;
         ii <= '0;
         ri <= '0;
      end else if (en) begin
         rr <= re_x_s * re_x_s;
         ii <= im_x_s * im_x_s;
         ri <= re_x_s * im_x_s;
      end else begin
         rr <= rr;
         ii <= ii;
         ri <= ri;
      end
   end

endmodule

// File: rtl/julia_iter_engine.sv
// Julia iteration engine. It iterates z <- z^2 + c on one point until
// |z|^2 > 4.0 or MAX_ITER updates are done. It then reports the count, the
// escape flag, the final z and a sticky overflow flag.
// Build option: JULIA_SAT_EN makes an overflowing update clamp; without it the update wraps.
module julia_iter_engine
   import julia_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 28,
   parameter int CNT_W    = 16,
   parameter int MAX_ITER = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] z_re_in,
   input  logic [WIDTH-1:0] z_im_in,
   input  logic [WIDTH-1:0] c_re_in,
   input  logic [WIDTH-1:0] c_im_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] iter_count,
   output logic             escaped,
   output logic [WIDTH-1:0] z_re_out,
   output logic [WIDTH-1:0] z_im_out,
   output logic             overflow
);

   localparam int PW = 2 * WIDTH;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic signed [WIDTH-1:0] z_re_r;
   logic signed [WIDTH-1:0] z_im_r;
   logic signed [WIDTH-1:0] c_re_r;
   logic signed [WIDTH-1:0] c_im_r;
   logic [CNT_W-1:0]        count_r;
   logic [CNT_W-1:0]        count_inc_s;
   logic                    esc_r;
   logic                    ovf_r;
   logic signed [PW-1:0]    rr_s;
   logic signed [PW-1:0]    ii_s;
   logic signed [PW-1:0]    ri_s;
   wide_t                   rr_w_s;
   wide_t                   ii_w_s;
   wide_t                   ri_w_s;
   wide_t                   c_re_w_s;
   wide_t                   c_im_w_s;
   wide_t                   mag_w_s;
   wide_t                   re_new_w_s;
   wide_t                   im_new_w_s;
   sow_t                    re_res_s;
   sow_t                    im_res_s;
   logic                    escape_s;
   logic                    last_s;
   logic                    unused_hi_s;

   julia_csq_stage #(
      .WIDTH (WIDTH)
   ) u_csq (
      .clk (clk),
      .rst (rst),
      .clr (abort),
      .en  (state_r == MUL),
      .re  (z_re_r),
      .im  (z_im_r),
      .rr  (rr_s),
      .ii  (ii_s),
      .ri  (ri_s)
   );

   // Escape test and candidate update, computed on wide intermediates so nothing wraps before the range check.
   always_comb begin
      rr_w_s      = {{(WIDE_W - PW){rr_s[PW-1]}}, rr_s};
      ii_w_s      = {{(WIDE_W - PW){ii_s[PW-1]}}, ii_s};
      ri_w_s      = {{(WIDE_W - PW){ri_s[PW-1]}}, ri_s};
      c_re_w_s    = {{(WIDE_W - WIDTH){c_re_r[WIDTH-1]}}, c_re_r};
      c_im_w_s    = {{(WIDE_W - WIDTH){c_im_r[WIDTH-1]}}, c_im_r};
      mag_w_s     = rr_w_s + ii_w_s;
      escape_s    = (mag_w_s > esc_thresh(FRAC));
      re_new_w_s  = ((rr_w_s - ii_w_s) >>> FRAC) + c_re_w_s;
      im_new_w_s  = ((ri_w_s <<< 1'b1) >>> FRAC) + c_im_w_s;
      re_res_s    = sat_or_wrap(re_new_w_s, WIDTH);
      im_res_s    = sat_or_wrap(im_new_w_s, WIDTH);
      count_inc_s = count_r + {{(CNT_W - 1){1'b0}}, 1'b1};
      last_s      = (count_inc_s == CNT_W'(MAX_ITER));
      // Helper bits above WIDTH are dropped when the result is narrowed.
      unused_hi_s = ^{re_res_s.val, im_res_s.val};
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (abort) begin
               state_nxt_s = IDLE;
            end else if (in_valid) begin
               state_nxt_s = MUL;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MUL: begin
            if (abort) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = ADD;
            end
         end
         ADD: begin
            if (abort) begin
               state_nxt_s = IDLE;
            end else if (escape_s || last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = MUL;
            end
         end
         DONE: begin
            if (abort || out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Point datapath: latch on accept, update z in ADD, record escape; hold during abort.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z_re_r  <= '0;
         z_im_r  <= '0;
         c_re_r  <= '0;
         c_im_r  <= '0;
         count_r <= '0;
         esc_r   <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (!abort) begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  z_re_r  <= z_re_in;
                  z_im_r  <= z_im_in;
                  c_re_r  <= c_re_in;
                  c_im_r  <= c_im_in;
                  count_r <= '0;
                  esc_r   <= 1'b0;
                  ovf_r   <= 1'b0;
               end else begin
                  count_r <= count_r;
               end
            end
            ADD: begin
               if (escape_s) begin
                  esc_r <= 1'b1;
               end else begin
                  z_re_r  <= re_res_s.val[WIDTH-1:0];
                  z_im_r  <= im_res_s.val[WIDTH-1:0];
                  count_r <= count_inc_s;
                  ovf_r   <= ovf_r | re_res_s.ovf | im_res_s.ovf;
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end else begin
         count_r <= count_r;
      end
   end

   assign in_ready   = (state_r == IDLE);
   assign out_valid  = (state_r == DONE);
   assign iter_count = count_r;
   assign escaped    = esc_r;
   assign z_re_out   = z_re_r;
   assign z_im_out   = z_im_r;
   assign overflow   = ovf_r;

endmodule
